// File: rtl/interrupt_ctrl_pkg.sv
// Shared types and constants for the interrupt controller: dispatch FSM states,
// default register addresses and vectors, and named interrupt source indices.
package interrupt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } int_state_t;

   localparam logic [15:0] DEF_IF_ADDR    = 16'hFF0F;
   localparam logic [15:0] DEF_IE_ADDR    = 16'hFFFF;
   localparam logic [15:0] DEF_VEC_BASE   = 16'h0040;
   localparam int unsigned DEF_VEC_STRIDE = 8;

   localparam int VBLANK  = 0;
   localparam int LCDSTAT = 1;
   localparam int TIMER   = 2;
   localparam int SERIAL  = 3;
   localparam int JOYPAD  = 4;

endpackage

// File: rtl/interrupt_ctrl_if.sv
// CPU-side bus and dispatch handshake of the interrupt controller.
// The CPU core holds the master modport, the controller the slave modport.
interface interrupt_ctrl_if;

   logic [15:0] I_CPU_ADDR;
   logic [7:0]  I_CPU_DATA;
   logic        I_MEM_WE_L;
   logic        I_IME;
   logic        I_INT_ACK;
   logic [7:0]  O_RD_DATA;
   logic        O_HIT;
   logic        O_INT_REQ;
   logic [15:0] O_INT_VECTOR;

   modport master (
      output I_CPU_ADDR, I_CPU_DATA, I_MEM_WE_L, I_IME, I_INT_ACK,
      input  O_RD_DATA, O_HIT, O_INT_REQ, O_INT_VECTOR
   );

   modport slave (
      input  I_CPU_ADDR, I_CPU_DATA, I_MEM_WE_L, I_IME, I_INT_ACK,
      output O_RD_DATA, O_HIT, O_INT_REQ, O_INT_VECTOR
   );

endinterface

// File: rtl/interrupt_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: reports the index of the lowest set
// request bit and whether any bit is set.
module int_prio_enc #(
   parameter  int N = 5,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_req,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_ctrl.sv
// Game Boy style interrupt controller: owns IF/IE, edge-detects sources,
// serves CPU reads/writes and runs the request/acknowledge dispatch handshake.
module interrupt_ctrl
   import interrupt_pkg::*;
#(
   parameter int          NUM_SRC    = 5,
   parameter logic [15:0] IF_ADDR    = DEF_IF_ADDR,
   parameter logic [15:0] IE_ADDR    = DEF_IE_ADDR,
   parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
   parameter int unsigned VEC_STRIDE = DEF_VEC_STRIDE
) (
   input  logic               I_CLOCK,
   input  logic               I_RESET,
   input  logic [NUM_SRC-1:0] I_SRC,
   interrupt_ctrl_if.slave    bus,
   output logic [NUM_SRC-1:0] O_SRC_ACK,
   output logic [NUM_SRC-1:0] O_IF,
   output logic [NUM_SRC-1:0] O_IE
);

   localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   int_state_t         r_state, w_state_next;
   logic [SEL_W-1:0]   r_sel, w_sel_next;
   logic [NUM_SRC-1:0] r_prev, r_if, r_ie, r_src_ack;
   logic [NUM_SRC-1:0] w_edge, w_pending, w_sel_hot, w_clear;
   logic [NUM_SRC-1:0] w_if_base, w_if_next, w_ie_next;
   logic [SEL_W-1:0]   w_win_idx;
   logic               w_win_valid, w_sel_pending;
   logic               w_if_hit, w_ie_hit, w_we;
   logic [7:0]         w_if_rd, w_ie_rd;
   logic [31:0]        w_vec_full;
   logic               w_unused_data;

   assign w_if_hit  = (bus.I_CPU_ADDR == IF_ADDR);
   assign w_ie_hit  = (bus.I_CPU_ADDR == IE_ADDR);
   assign w_we      = ~bus.I_MEM_WE_L;
   assign w_edge    = I_SRC & ~r_prev;
   assign w_pending = r_if & r_ie;
   assign w_unused_data = &{1'b0, bus.I_CPU_DATA};

   // Hardware set is ORed in last so it beats both a CPU write and a dispatch clear.
   assign w_clear   = ((r_state == REQ) && bus.I_INT_ACK) ? w_sel_hot : '0;
   assign w_if_base = (w_we && w_if_hit) ? bus.I_CPU_DATA[NUM_SRC-1:0] : r_if;
   assign w_if_next = (w_if_base & ~w_clear) | w_edge;
   assign w_ie_next = (w_we && w_ie_hit) ? bus.I_CPU_DATA[NUM_SRC-1:0] : r_ie;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sel_hot
         assign w_sel_hot[gi] = (r_sel == SEL_W'(gi));
      end
      for (genvar gi = 0; gi < 8; gi++) begin : g_rd
         if (gi < NUM_SRC) begin : g_used
            assign w_if_rd[gi] = r_if[gi];
            assign w_ie_rd[gi] = r_ie[gi];
         end else begin : g_pad
            assign w_if_rd[gi] = 1'b1;
            assign w_ie_rd[gi] = 1'b0;
         end
      end
   endgenerate

   assign w_sel_pending = |(w_pending & w_sel_hot);

   int_prio_enc #(.N(NUM_SRC)) u_prio_enc (
      .i_req   (w_pending),
      .o_idx   (w_win_idx),
      .o_valid (w_win_valid)
   );

   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      case (r_state)
         IDLE: begin
            if (bus.I_IME && w_win_valid) begin
               w_sel_next   = w_win_idx;
               w_state_next = REQ;
            end
         end
         // sel stays frozen in REQ even if a higher-priority source shows up.
         REQ: begin
            if (bus.I_INT_ACK) begin
               w_state_next = ACK;
            end else if (!w_sel_pending || !bus.I_IME) begin
               w_state_next = IDLE;
            end
         end
         ACK:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) begin
         r_prev    <= '1;
         r_if      <= '0;
         r_ie      <= '0;
         r_state   <= IDLE;
         r_sel     <= '0;
         r_src_ack <= '0;
      end else begin
         r_prev    <= I_SRC;
         r_if      <= w_if_next;
         r_ie      <= w_ie_next;
         r_state   <= w_state_next;
         r_sel     <= w_sel_next;
         r_src_ack <= w_clear;
      end
   end

   assign w_vec_full = {16'd0, VEC_BASE} + 32'(r_sel) * 32'(VEC_STRIDE);

   assign bus.O_HIT        = w_if_hit | w_ie_hit;
   assign bus.O_RD_DATA    = w_if_hit ? w_if_rd : (w_ie_hit ? w_ie_rd : 8'hFF);
   assign bus.O_INT_REQ    = (r_state == REQ);
   assign bus.O_INT_VECTOR = w_vec_full[15:0];
   assign O_SRC_ACK        = r_src_ack;
   assign O_IF             = r_if;
   assign O_IE             = r_ie;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: a 5-source instance for the main
// handshake scenarios and an 8-source instance for the wide configuration.
module tb_interrupt_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] src5, ack5, if5, ie5;
   logic [7:0] src8, ack8, if8, ie8;
   int         n_chk = 0;
   int         n_err = 0;

   interrupt_ctrl_if bus5 ();
   interrupt_ctrl_if bus8 ();

   interrupt_ctrl u_dut5 (
      .I_CLOCK   (clk),
      .I_RESET   (rst),
      .I_SRC     (src5),
      .bus       (bus5),
      .O_SRC_ACK (ack5),
      .O_IF      (if5),
      .O_IE      (ie5)
   );

   interrupt_ctrl #(.NUM_SRC(8)) u_dut8 (
      .I_CLOCK   (clk),
      .I_RESET   (rst),
      .I_SRC     (src8),
      .bus       (bus8),
      .O_SRC_ACK (ack8),
      .O_IF      (if8),
      .O_IE      (ie8)
   );

   initial forever #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-12s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      rst = 1'b1;
      src5 = 5'h1F;
      src8 = 8'h00;
      bus5.I_CPU_ADDR = 16'h0000; bus5.I_CPU_DATA = 8'h00; bus5.I_MEM_WE_L = 1'b1;
      bus5.I_IME = 1'b0;          bus5.I_INT_ACK = 1'b0;
      bus8.I_CPU_ADDR = 16'h0000; bus8.I_CPU_DATA = 8'h00; bus8.I_MEM_WE_L = 1'b1;
      bus8.I_IME = 1'b0;          bus8.I_INT_ACK = 1'b0;

      tick(); tick();
      check("rst_if", 32'(if5), 32'h0);
      check("rst_ie", 32'(ie5), 32'h0);
      check("rst_req", 32'(bus5.O_INT_REQ), 32'h0);
      check("rst_vec", 32'(bus5.O_INT_VECTOR), 32'h0040);
      check("rst_ack", 32'(ack5), 32'h0);

      // Sources held high through reset must not fire.
      rst = 1'b0;
      bus5.I_IME = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_if", 32'(if5), 32'h0);
         check("hold_req", 32'(bus5.O_INT_REQ), 32'h0);
      end
      src5 = 5'h00;
      bus5.I_IME = 1'b0;

      // Enable all sources.
      bus5.I_CPU_ADDR = 16'hFFFF; bus5.I_CPU_DATA = 8'hFF; bus5.I_MEM_WE_L = 1'b0;
      tick();
      bus5.I_MEM_WE_L = 1'b1;
      check("ie_wr", 32'(ie5), 32'h1F);
      check("ie_rd", 32'(bus5.O_RD_DATA), 32'h1F);
      check("ie_hit", 32'(bus5.O_HIT), 32'h1);
      bus5.I_CPU_ADDR = 16'hFF0F;
      #1 check("if_rd0", 32'(bus5.O_RD_DATA), 32'hE0);
      bus5.I_CPU_ADDR = 16'h1234;
      #1 check("other_rd", 32'(bus5.O_RD_DATA), 32'hFF);
      check("other_hit", 32'(bus5.O_HIT), 32'h0);

      // TIMER edge -> request two cycles later with vector 0x50.
      bus5.I_IME = 1'b1;
      src5 = 5'b00100;
      tick();
      check("tmr_if", 32'(if5), 32'h04);
      check("tmr_req0", 32'(bus5.O_INT_REQ), 32'h0);
      tick();
      check("tmr_req", 32'(bus5.O_INT_REQ), 32'h1);
      check("tmr_vec", 32'(bus5.O_INT_VECTOR), 32'h0050);
      bus5.I_INT_ACK = 1'b1;
      tick();
      bus5.I_INT_ACK = 1'b0;
      check("tmr_ifclr", 32'(if5), 32'h00);
      check("tmr_ack", 32'(ack5), 32'h04);
      check("tmr_reqoff", 32'(bus5.O_INT_REQ), 32'h0);
      tick();
      check("tmr_ack1", 32'(ack5), 32'h00);
      check("tmr_idle", 32'(bus5.O_INT_REQ), 32'h0);
      src5 = 5'h00;
      tick();

      // JOYPAD and VBLANK together: VBLANK first, then JOYPAD.
      src5 = 5'b10001;
      tick();
      check("jv_if", 32'(if5), 32'h11);
      tick();
      check("jv_vec0", 32'(bus5.O_INT_VECTOR), 32'h0040);
      check("jv_req0", 32'(bus5.O_INT_REQ), 32'h1);
      bus5.I_INT_ACK = 1'b1;
      tick();
      bus5.I_INT_ACK = 1'b0;
      check("jv_ack0", 32'(ack5), 32'h01);
      check("jv_if1", 32'(if5), 32'h10);
      tick();
      check("jv_gap", 32'(bus5.O_INT_REQ), 32'h0);
      tick();
      check("jv_req1", 32'(bus5.O_INT_REQ), 32'h1);
      check("jv_vec1", 32'(bus5.O_INT_VECTOR), 32'h0060);
      bus5.I_INT_ACK = 1'b1;
      tick();
      bus5.I_INT_ACK = 1'b0;
      check("jv_ack1", 32'(ack5), 32'h10);
      tick();
      src5 = 5'h00;
      tick();

      // SERIAL request cancelled by clearing IE.
      src5 = 5'b01000;
      tick();
      tick();
      check("ser_vec", 32'(bus5.O_INT_VECTOR), 32'h0058);
      check("ser_req", 32'(bus5.O_INT_REQ), 32'h1);
      bus5.I_CPU_ADDR = 16'hFFFF; bus5.I_CPU_DATA = 8'h00; bus5.I_MEM_WE_L = 1'b0;
      tick();
      bus5.I_MEM_WE_L = 1'b1;
      check("ser_ie0", 32'(ie5), 32'h00);
      check("ser_noack0", 32'(ack5), 32'h00);
      tick();
      check("ser_drop", 32'(bus5.O_INT_REQ), 32'h0);
      check("ser_if", 32'(if5), 32'h08);
      check("ser_noack", 32'(ack5), 32'h00);

      // CPU clears IF while a LCDSTAT edge arrives: the edge wins.
      bus5.I_IME = 1'b0;
      src5 = 5'b00010;
      bus5.I_CPU_ADDR = 16'hFF0F; bus5.I_CPU_DATA = 8'h00; bus5.I_MEM_WE_L = 1'b0;
      tick();
      bus5.I_MEM_WE_L = 1'b1;
      check("lcd_if", 32'(if5), 32'h02);
      check("lcd_rd", 32'(bus5.O_RD_DATA), 32'hE2);

      // Same-bit edge and ack: bit stays set, ack pulses, re-requested.
      src5 = 5'h00;
      bus5.I_CPU_ADDR = 16'hFFFF; bus5.I_CPU_DATA = 8'h1F; bus5.I_MEM_WE_L = 1'b0;
      tick();
      bus5.I_MEM_WE_L = 1'b1;
      bus5.I_IME = 1'b1;
      tick();
      check("sb_req", 32'(bus5.O_INT_REQ), 32'h1);
      check("sb_vec", 32'(bus5.O_INT_VECTOR), 32'h0048);
      bus5.I_INT_ACK = 1'b1;
      src5 = 5'b00010;
      tick();
      bus5.I_INT_ACK = 1'b0;
      check("sb_if", 32'(if5), 32'h02);
      check("sb_ack", 32'(ack5), 32'h02);
      tick();
      check("sb_gap", 32'(bus5.O_INT_REQ), 32'h0);
      tick();
      check("sb_rereq", 32'(bus5.O_INT_REQ), 32'h1);
      check("sb_revec", 32'(bus5.O_INT_VECTOR), 32'h0048);

      // Reset during REQ with ack asserted: no ack pulse, everything cleared.
      rst = 1'b1;
      bus5.I_INT_ACK = 1'b1;
      tick();
      rst = 1'b0;
      bus5.I_INT_ACK = 1'b0;
      check("mr_req", 32'(bus5.O_INT_REQ), 32'h0);
      check("mr_ack", 32'(ack5), 32'h00);
      check("mr_if", 32'(if5), 32'h00);
      check("mr_ie", 32'(ie5), 32'h00);
      check("mr_vec", 32'(bus5.O_INT_VECTOR), 32'h0040);

      // Eight-source instance: source 7 vectors to 0x78, IE reads all bits.
      bus8.I_CPU_ADDR = 16'hFFFF; bus8.I_CPU_DATA = 8'hFF; bus8.I_MEM_WE_L = 1'b0;
      tick();
      bus8.I_MEM_WE_L = 1'b1;
      check("w8_ie_rd", 32'(bus8.O_RD_DATA), 32'hFF);
      bus8.I_IME = 1'b1;
      src8 = 8'h80;
      tick();
      check("w8_if", 32'(if8), 32'h80);
      tick();
      check("w8_req", 32'(bus8.O_INT_REQ), 32'h1);
      check("w8_vec", 32'(bus8.O_INT_VECTOR), 32'h0078);
      bus8.I_CPU_ADDR = 16'hFF0F;
      #1 check("w8_if_rd", 32'(bus8.O_RD_DATA), 32'h80);
      bus8.I_INT_ACK = 1'b1;
      tick();
      bus8.I_INT_ACK = 1'b0;
      check("w8_ack", 32'(ack8), 32'h80);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
